// File: rtl/arena_pkg.sv
// Shared types and constants for the tank arena round controller.
package arena_pkg;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_EXPLODE, S_OVER} arena_state_t;

   localparam logic [7:0] START_KEY_DEFAULT = 8'd40;

   // Bits needed to hold a health value in 0..max_health.
   function automatic int arena_hw(input int max_health);
      return $clog2(max_health + 1);
   endfunction

endpackage

// File: rtl/tank_vitals.sv
// Per-tank vitals: hit/pickup edge detection, saturating health, shield timer,
// alive and dying flags.
module tank_vitals import arena_pkg::*; #(
   parameter int MAX_HEALTH    = 32,
   parameter int DAMAGE        = 4,
   parameter int SHIELD_FRAMES = 300,
   parameter int HW            = arena_hw(MAX_HEALTH)
) (
   input  logic          frame_clk,
   input  logic          Reset,
   input  logic          round_start,
   input  logic          in_play,
   input  logic          in_explode,
   input  logic          hit,
   input  logic          shield_pickup,
   output logic [HW-1:0] health,
   output logic          alive,
   output logic          shield_on,
   output logic          dying
);

   localparam int SW       = $clog2(SHIELD_FRAMES + 1);
   localparam int DMG_CLIP = (DAMAGE > MAX_HEALTH) ? MAX_HEALTH : DAMAGE;

   localparam logic [HW-1:0] FULL        = HW'(MAX_HEALTH);
   localparam logic [HW-1:0] DMG         = HW'(DMG_CLIP);
   localparam logic [SW-1:0] SHIELD_LOAD = SW'(SHIELD_FRAMES);

   logic          hit_q;
   logic          pickup_q;
   logic          hit_edge;
   logic          pickup_edge;
   logic [SW-1:0] timer;

   assign hit_edge    = hit & ~hit_q;
   assign pickup_edge = shield_pickup & ~pickup_q;

   // NOTE: reset is synchronous and every state element uses <= so all flops
   // sample the same pre-edge values regardless of statement order.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         hit_q     <= 1'b0;
         pickup_q  <= 1'b0;
         health    <= FULL;
         alive     <= 1'b1;
         shield_on <= 1'b0;
         dying     <= 1'b0;
         timer     <= '0;
      end else begin
         hit_q    <= hit;
         pickup_q <= shield_pickup;
         if (round_start) begin
            health    <= FULL;
            alive     <= 1'b1;
            shield_on <= 1'b0;
            dying     <= 1'b0;
            timer     <= '0;
         end else if (in_play && alive) begin
            if (hit_edge && !shield_on && (health <= DMG)) begin
               // Fatal hit: the tank leaves the round and loses its shield.
               health    <= '0;
               alive     <= 1'b0;
               dying     <= 1'b1;
               shield_on <= 1'b0;
               timer     <= '0;
            end else begin
               if (hit_edge && !shield_on)
                  health <= health - DMG;
               if (pickup_edge) begin
                  timer     <= SHIELD_LOAD;
                  shield_on <= 1'b1;
               end else if (timer != '0) begin
                  timer <= timer - 1'b1;
                  if (timer == SW'(1))
                     shield_on <= 1'b0;
               end
            end
         end else if ((in_play || in_explode) && (timer != '0)) begin
            timer <= timer - 1'b1;
            if (timer == SW'(1))
               shield_on <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/arena_match_ctrl.sv
// Round controller for N_TANKS players: round FSM, explosion timer, survivor
// count and winner latch around one tank_vitals per tank.
module arena_match_ctrl import arena_pkg::*; #(
   parameter int          N_TANKS        = 4,
   parameter int          MAX_HEALTH     = 32,
   parameter int          DAMAGE         = 4,
   parameter int          SHIELD_FRAMES  = 300,
   parameter int          EXPLODE_FRAMES = 60,
   parameter logic [7:0]  START_KEY      = START_KEY_DEFAULT,
   parameter int          HW             = arena_hw(MAX_HEALTH),
   parameter int          IW             = (N_TANKS > 2) ? $clog2(N_TANKS) : 1
) (
   input  logic                  frame_clk,
   input  logic                  Reset,
   input  logic [7:0]            keycode,
   input  logic [N_TANKS-1:0]    hit,
   input  logic [N_TANKS-1:0]    shield_pickup,
   output logic [N_TANKS*HW-1:0] health,
   output logic [N_TANKS-1:0]    alive,
   output logic [N_TANKS-1:0]    shield_on,
   output logic [N_TANKS-1:0]    dying,
   output logic                  game_on,
   output logic                  explosion_on,
   output logic                  round_over,
   output logic                  round_reset,
   output logic [IW-1:0]         winner,
   output logic                  winner_valid
);

   localparam int PW = $clog2(N_TANKS + 1);
   localparam int CW = $clog2(EXPLODE_FRAMES + 1);

   arena_state_t  state;
   arena_state_t  next_state;
   logic          round_start;
   logic [PW-1:0] alive_cnt;
   logic [IW-1:0] win_idx;
   logic [CW-1:0] explode_cnt;

   assign round_start = ((state == S_IDLE) || (state == S_OVER)) && (keycode == START_KEY);

   for (genvar i = 0; i < N_TANKS; i++) begin : g_tank
      tank_vitals #(
         .MAX_HEALTH    (MAX_HEALTH),
         .DAMAGE        (DAMAGE),
         .SHIELD_FRAMES (SHIELD_FRAMES),
         .HW            (HW)
      ) u_vitals (
         .frame_clk     (frame_clk),
         .Reset         (Reset),
         .round_start   (round_start),
         .in_play       (state == S_PLAY),
         .in_explode    (state == S_EXPLODE),
         .hit           (hit[i]),
         .shield_pickup (shield_pickup[i]),
         .health        (health[i*HW +: HW]),
         .alive         (alive[i]),
         .shield_on     (shield_on[i]),
         .dying         (dying[i])
      );
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      alive_cnt = '0;
      win_idx   = '0;
      for (int i = 0; i < N_TANKS; i++) begin
         alive_cnt = alive_cnt + PW'(alive[i]);
         if (alive[i])
            win_idx = IW'(i);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:    if (round_start) next_state = S_PLAY;
         S_PLAY:    if (alive_cnt <= PW'(1)) next_state = S_EXPLODE;
         S_EXPLODE: if (explode_cnt == CW'(EXPLODE_FRAMES - 1)) next_state = S_OVER;
         S_OVER:    if (round_start) next_state = S_PLAY;
         default:   next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         explode_cnt  <= '0;
         game_on      <= 1'b0;
         explosion_on <= 1'b0;
         round_over   <= 1'b0;
         round_reset  <= 1'b0;
         winner       <= '0;
         winner_valid <= 1'b0;
      end else begin
         state        <= next_state;
         game_on      <= (next_state == S_PLAY);
         explosion_on <= (next_state == S_EXPLODE);
         round_over   <= (next_state == S_OVER);
         round_reset  <= round_start;
         explode_cnt  <= (state == S_EXPLODE) ? explode_cnt + 1'b1 : '0;
         // Zero survivors at the transition is a draw: winner_valid stays low.
         if ((state == S_PLAY) && (next_state == S_EXPLODE)) begin
            winner       <= win_idx;
            winner_valid <= (alive_cnt == PW'(1));
         end else if (round_start) begin
            winner_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/arena_match_ctrl.md
# arena_match_ctrl

Parametrised round controller for the tank arena, generalising today's fixed two-tank health/game-state wiring to `N_TANKS` players. Per tank, it tracks:
- health with edge-detected hits and saturating damage,
- a timed shield,
- alive status.

It runs the round state machine (idle, play, explosion, round over) and reports a winner or a draw. It sits between the collision handler / pickup logic and the color mapper, clocked once per video frame.

## Interface
Parameters:
- `N_TANKS`, 4: number of tanks, 2..8.
- `MAX_HEALTH`, 32: health loaded at round start, 1..255.
- `DAMAGE`, 4: health removed per accepted hit.
- `SHIELD_FRAMES`, 300: shield duration in frames, ≥1.
- `EXPLODE_FRAMES`, 60: length of the explosion phase in frames, ≥1.
- `START_KEY`, 8'd40: keycode that starts a round (Enter).

Derived widths: `HW = $clog2(MAX_HEALTH+1)`; `IW = max(1, $clog2(N_TANKS))`.

Ports:
- `frame_clk`  in  1  the only clock (VGA vsync); one cycle = one frame.
- `Reset`  in  1  synchronous, active-high.
- `keycode`  in  8  current USB keycode.
- `hit`  in  N_TANKS  per-tank bullet-collision level; may stay high for several frames.
- `shield_pickup`  in  N_TANKS  per-tank shield pickup level.
- `health`  out  N_TANKS*HW  packed health; tank i occupies `[i*HW +: HW]`.
- `alive`  out  N_TANKS  tank still in the round.
- `shield_on`  out  N_TANKS  shield currently active.
- `dying`  out  N_TANKS  tank whose health reached 0 during the current play/explosion phase.
- `game_on`  out  1  state is PLAY.
- `explosion_on`  out  1  state is EXPLODE.
- `round_over`  out  1  state is OVER.
- `round_reset`  out  1  one-frame pulse when a round starts; resets bullets and animators.
- `winner`  out  IW  index of the surviving tank; valid only with `winner_valid`.
- `winner_valid`  out  1  exactly one survivor at end of round.

## Operation
State machine:
- **IDLE**: go to PLAY when `keycode == START_KEY`.
- **PLAY**: go to EXPLODE once popcount(`alive`) ≤ 1.
- **EXPLODE**: count `EXPLODE_FRAMES` frames, then go to OVER.
- **OVER**: go to PLAY when `keycode == START_KEY`.

Entering PLAY (from either IDLE or OVER):
- `round_reset` = 1 for that frame only.
- All health = `MAX_HEALTH`; `alive` = all ones; `shield_on`, `dying` and all shield timers = 0.
- `winner_valid` = 0.
- Holding `START_KEY` does not retrigger while in PLAY.

Hits:
- A hit is accepted on the rising edge of `hit[i]`, i.e. `hit[i]` now high and low in the previous frame.
- Edge registers update in every state.
- A hit is acted on only in PLAY and only for an alive tank.
- Accepted hit with shield off: health = `health - DAMAGE`, saturating at 0.
- Accepted hit with shield on: absorbed; health unchanged and shield not consumed.
- When health becomes 0, that frame sets `alive[i]` = 0 and `dying[i]` = 1.

Shields:
- On a rising edge of `shield_pickup[i]` in PLAY for an alive tank, the shield timer loads `SHIELD_FRAMES` and `shield_on[i]` = 1.
- A pickup while the shield is already active reloads the timer.
- The timer decrements every frame in PLAY and EXPLODE; `shield_on[i]` clears when it reaches 0.
- Death clears that tank's shield.

End of round (PLAY to EXPLODE):
- Winner is latched at the transition.
- If exactly one tank is alive: `winner` = its index, `winner_valid` = 1.
- If zero are alive (simultaneous final kills): `winner_valid` = 0, meaning a draw.
- Multiple tanks dying in the same frame are all processed in that frame.

Outside PLAY, health, alive and shields hold, except that shield timers keep counting in EXPLODE.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Reset values:
  - state IDLE;
  - health = `MAX_HEALTH` for every tank;
  - `alive` all ones;
  - `shield_on`, `dying` = 0;
  - `game_on`, `explosion_on`, `round_over`, `round_reset` = 0;
  - `winner` = 0, `winner_valid` = 0;
  - hit/pickup edge registers = 0, so a hit held high through Reset release counts as an edge.
- Start key sampled in frame t: `game_on` and `round_reset` are high in frame t+1.
- Hit edge in frame t: new health is visible in frame t+1.
- Fatal hit in frame t: `alive` drops in t+1, `explosion_on` rises in t+2, `round_over` rises in t+2+`EXPLODE_FRAMES`.
- Reset during any state returns to the reset values on the next edge; no pulse is emitted.

## Structure
- Package `arena_pkg` holds:
  - `typedef enum logic [1:0] {S_IDLE, S_PLAY, S_EXPLODE, S_OVER} arena_state_t`;
  - default `START_KEY` constant;
  - `arena_hw` width function.
- Sub-module `tank_vitals` handles one tank: edge detectors, health saturation, shield timer, alive/dying. The top instantiates it `N_TANKS` times with a generate loop, and contains the FSM, explosion counter, popcount and winner encoder.

## Test plan
Defaults unless noted (`N_TANKS` = 4, `MAX_HEALTH` = 32, `DAMAGE` = 4).
- **Start**: Reset, then `keycode` = 40 for 3 frames → `round_reset` high exactly 1 frame, all health 32, `alive` = 4'b1111, `game_on` = 1.
- **Held hit**: `hit[1]` held for 5 frames → health[1] = 28 (one hit only). Release, then 8 more single pulses → health[1] = 0, `alive[1]` = 0, `dying[1]` = 1.
- **Shield**: `shield_pickup[2]` pulse, then `hit[2]` pulse 10 frames later → health[2] stays 32. After 300 frames `shield_on[2]` = 0, and the next hit gives 28.
- **Winner**: kill tanks 0, 1 and 3 → `explosion_on` for 60 frames, then `round_over` = 1, `winner` = 2, `winner_valid` = 1. `keycode` = 40 then starts a new round with health restored.
- **Draw and reset**:
  - With `N_TANKS` = 2 and `MAX_HEALTH` = `DAMAGE` = 4, hit both tanks in the same frame → `winner_valid` = 0 after EXPLODE.
  - Assert Reset mid-EXPLODE → IDLE next frame, with all outputs at their reset values.
